ir_nec_decoder: RTL



---
 rtl/ir_nec_pkg.sv | 47 ++++
 rtl/ir_edge_sync.sv | 31 +++
 rtl/ir_nec_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ir_nec_pkg.sv
// Shared types and timing windows for the NEC infrared decoder.
// All windows are in microseconds; the decoder scales them to its tick unit.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  localparam int LEAD_LOW_MIN  = 8000;
  localparam int LEAD_LOW_MAX  = 10000;
  localparam int LEAD_HIGH_MIN = 4000;
  localparam int LEAD_HIGH_MAX = 5000;
  localparam int REP_HIGH_MIN  = 1800;
  localparam int REP_HIGH_MAX  = 2700;
  localparam int BIT_LOW_MIN   = 400;
  localparam int BIT_LOW_MAX   = 750;
  localparam int ZERO_MIN      = 400;
  localparam int ZERO_MAX      = 750;
  localparam int ONE_MIN       = 1400;
  localparam int ONE_MAX       = 1900;

  localparam int DUR_W     = 15;
  localparam int FRAME_W   = 32;
  localparam int BIT_CNT_W = 6;
  localparam int BYTE_W    = 8;

  // Frame field positions (LSB of each byte)
  localparam int ADDR_LSB  = 0;
  localparam int NADDR_LSB = 8;
  localparam int CMD_LSB   = 16;
  localparam int NCMD_LSB  = 24;

  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    return (f[CMD_LSB +: BYTE_W] == ~f[NCMD_LSB +: BYTE_W]) &&
           (f[ADDR_LSB +: BYTE_W] == ~f[NADDR_LSB +: BYTE_W]);
  endfunction

  function automatic logic in_win(input logic [DUR_W-1:0] d, input int lo, input int hi);
    return (int'(d) >= lo) && (int'(d) <= hi);
  endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus single-cycle rise/fall strobes.
// Shared with the KEY debouncer; IDLE_LEVEL sets the reset value of every flop.
module ir_edge_sync #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= IDLE_LEVEL;
      sync <= IDLE_LEVEL;
      prev <= IDLE_LEVEL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: measures line levels in µs ticks and walks the
// leader / 32-bit / stop-burst sequence, emitting data, repeat and error strobes.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int CLK_PER_US = 50,
  parameter int TIMEOUT_US = 12000,
  // Divides every window and the timeout; 1 in hardware, larger to compress time in simulation
  parameter int TIME_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_rxd,
  output logic [31:0] data,
  output logic        data_ready,
  output logic        repeat_pulse,
  output logic        frame_err
);

  localparam int PW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int LL_MIN    = LEAD_LOW_MIN / TIME_DIV;
  localparam int LL_MAX    = LEAD_LOW_MAX / TIME_DIV;
  localparam int LH_MIN    = LEAD_HIGH_MIN / TIME_DIV;
  localparam int LH_MAX    = LEAD_HIGH_MAX / TIME_DIV;
  localparam int RH_MIN    = REP_HIGH_MIN / TIME_DIV;
  localparam int RH_MAX    = REP_HIGH_MAX / TIME_DIV;
  localparam int BL_MIN    = BIT_LOW_MIN / TIME_DIV;
  localparam int BL_MAX    = BIT_LOW_MAX / TIME_DIV;
  localparam int Z_MIN     = ZERO_MIN / TIME_DIV;
  localparam int Z_MAX     = ZERO_MAX / TIME_DIV;
  localparam int O_MIN     = ONE_MIN / TIME_DIV;
  localparam int O_MAX     = ONE_MAX / TIME_DIV;
  localparam int TIMEOUT_T = TIMEOUT_US / TIME_DIV;

  logic                 rise, fall;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [DUR_W-1:0]     dur;
  logic                 timeout;

  state_t               state, state_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [FRAME_W-1:0]   sr, sr_n;
  logic                 load, dr_n, rep_n, err_n;

  ir_edge_sync #(.IDLE_LEVEL(1'b1)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ir_rxd),
    .rise (rise),
    .fall (fall)
  );

  assign tick = (presc == PW'(CLK_PER_US - 1));

  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Duration of the current level; the value seen on an edge is the level just ended
  always_ff @(posedge clk) begin
    if (rst)                    dur <= '0;
    else if (rise || fall)      dur <= '0;
    else if (tick && dur != '1) dur <= dur + 1'b1;
  end

  assign timeout = (state != IDLE) && (dur >= DUR_W'(TIMEOUT_T));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      sr           <= '0;
      data         <= '0;
      data_ready   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      sr           <= sr_n;
      data_ready   <= dr_n;
      repeat_pulse <= rep_n;
      frame_err    <= err_n;
      if (load) data <= sr;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    load      = 1'b0;
    dr_n      = 1'b0;
    rep_n     = 1'b0;
    err_n     = 1'b0;

    if (timeout) begin
      err_n   = 1'b1;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (fall) state_n = LEAD_LOW;

        // A short low burst outside a frame is treated as noise, not an error
        LEAD_LOW: if (rise) state_n = in_win(dur, LL_MIN, LL_MAX) ? LEAD_HIGH : IDLE;

        LEAD_HIGH: if (fall) begin
          if (in_win(dur, LH_MIN, LH_MAX)) begin
            state_n   = BIT_LOW;
            bit_cnt_n = '0;
          end else if (in_win(dur, RH_MIN, RH_MAX)) begin
            rep_n   = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end

        BIT_LOW: if (rise) begin
          if (!in_win(dur, BL_MIN, BL_MAX)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (bit_cnt == BIT_CNT_W'(FRAME_W)) begin
            state_n = CHECK;
          end else begin
            state_n = BIT_HIGH;
          end
        end

        // LSB-first: new bits enter at the top so the first bit ends in bit 0
        BIT_HIGH: if (fall) begin
          if (in_win(dur, Z_MIN, Z_MAX) || in_win(dur, O_MIN, O_MAX)) begin
            sr_n      = {in_win(dur, O_MIN, O_MAX), sr[FRAME_W-1:1]};
            bit_cnt_n = bit_cnt + 1'b1;
            state_n   = BIT_LOW;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end

        CHECK: begin
          if (frame_ok(sr)) begin
            load = 1'b1;
            dr_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule
